// File: rtl/serialize_sched_pkg.sv
// Shared definitions for the serialize-chain scheduler: state encoding and
// a helper that sizes the channel-index field from the chain length.
package serialize_sched_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    StIdle = ST_IDLE,
    StRun  = ST_RUN
  } state_e;

  // Smallest chan_idx width able to hold indices 0..n-1.
  function automatic int unsigned min_chw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serialize_sched_if.sv
// Control and tail-stream bundle between the scheduler, the cell chain and
// the consumer. master = scheduler side, slave = environment side.
interface serialize_sched_if
  import serialize_sched_pkg::*;
#(
  parameter int unsigned cw  = 16,
  parameter int unsigned chw = 3
);

  logic           enable;
  logic [cw-1:0]  period;
  logic           samp;
  logic           tail_gate;
  logic           chan_valid;
  logic [chw-1:0] chan_idx;
  logic           frame_start;
  logic           frame_end;
  logic           in_flight;
  logic           overrun;
  logic           short_frame;
  logic           err_clr;

  modport master (
    input  enable, period, tail_gate, err_clr,
    output samp, chan_valid, chan_idx, frame_start, frame_end, in_flight, overrun,
           short_frame
  );

  modport slave (
    output enable, period, tail_gate, err_clr,
    input  samp, chan_valid, chan_idx, frame_start, frame_end, in_flight, overrun,
           short_frame
  );

endinterface

// File: rtl/serialize_frame_track.sv
// Tail-word tracker: labels words leaving the chain with channel index and
// frame boundaries, tracks the in-flight frame and latches error flags.
module serialize_frame_track
  import serialize_sched_pkg::*;
#(
  parameter int unsigned n_chan = 8,
  parameter int unsigned chw    = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           samp,
  input  logic           tail_gate,
  input  logic           err_clr,
  output logic           chan_valid,
  output logic [chw-1:0] chan_idx,
  output logic           frame_start,
  output logic           frame_end,
  output logic           in_flight,
  output logic           overrun,
  output logic           short_frame
);

  logic [chw-1:0] wcnt_q, wcnt_d;
  logic           armed_q;
  logic           tail_ok, last_word, fe_d, short_ev, overrun_ev;
  logic           in_flight_q, in_flight_d;
  logic           overrun_q, short_q;
  logic           chan_valid_q, frame_start_q, frame_end_q;
  logic [chw-1:0] chan_idx_q;

  always_comb begin
    // Words left in the chain across a reset are not ours until a new snap.
    tail_ok    = tail_gate & armed_q;
    last_word  = (wcnt_q == chw'(n_chan - 1));
    fe_d       = tail_ok & last_word;
    short_ev   = ~tail_ok & (wcnt_q != '0);
    overrun_ev = samp & in_flight_q & ~fe_d;

    wcnt_d = '0;
    if (!samp && tail_ok && !last_word) begin
      wcnt_d = wcnt_q + chw'(1);
    end

    // A truncated frame has drained as far as it ever will.
    in_flight_d = in_flight_q;
    if (samp) begin
      in_flight_d = 1'b1;
    end else if (fe_d || short_ev) begin
      in_flight_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q        <= '0;
      armed_q       <= 1'b0;
      in_flight_q   <= 1'b0;
      overrun_q     <= 1'b0;
      short_q       <= 1'b0;
      chan_valid_q  <= 1'b0;
      chan_idx_q    <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      wcnt_q        <= wcnt_d;
      armed_q       <= armed_q | samp;
      in_flight_q   <= in_flight_d;
      overrun_q     <= (overrun_q & ~err_clr) | overrun_ev;
      short_q       <= (short_q & ~err_clr) | short_ev;
      chan_valid_q  <= tail_ok;
      chan_idx_q    <= wcnt_q;
      frame_start_q <= tail_ok & (wcnt_q == '0);
      frame_end_q   <= fe_d;
    end
  end

  assign chan_valid  = chan_valid_q;
  assign chan_idx    = chan_idx_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign in_flight   = in_flight_q;
  assign overrun     = overrun_q;
  assign short_frame = short_q;

endmodule

// File: rtl/serialize_sched.sv
// Snap-strobe generator and tail tracker for a chain of serialize cells.
// Define SERIALIZE_SCHED_CLAMP_EN to stretch short periods to n_chan cycles.
module serialize_sched
  import serialize_sched_pkg::*;
#(
  parameter int unsigned n_chan = 8,
  parameter int unsigned cw     = 16,
  parameter int unsigned chw    = 3
) (
  input logic                clk,
  input logic                rst,
  serialize_sched_if.master  bus
);

  if (chw < min_chw(n_chan)) begin : g_bad_chw
    $error("serialize_sched: chw too small for n_chan");
  end

  state_e        state_q;
  logic [cw-1:0] cnt_q;
  logic [cw-1:0] eff_q;
  logic [cw-1:0] eff_new;
  logic          samp_q;
  logic          run_due;

  always_comb begin
    eff_new = (bus.period < cw'(2)) ? cw'(1) : bus.period;
`ifdef SERIALIZE_SCHED_CLAMP_EN
    if (eff_new < cw'(n_chan)) begin
      eff_new = cw'(n_chan);
    end
`endif
    // In the cycle after a snap the counter has not been reloaded yet, so the
    // captured period decides whether another snap is due immediately.
    run_due = samp_q ? (eff_q == cw'(1)) : (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      eff_q   <= '0;
      samp_q  <= 1'b0;
    end else begin
      samp_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (bus.enable) begin
            state_q <= StRun;
            samp_q  <= 1'b1;
            eff_q   <= eff_new;
          end
        end
        StRun: begin
          if (!bus.enable) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (run_due) begin
            samp_q <= 1'b1;
            eff_q  <= eff_new;
          end else if (samp_q) begin
            cnt_q <= eff_q - cw'(2);
          end else begin
            cnt_q <= cnt_q - cw'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.samp = samp_q;

  serialize_frame_track #(
    .n_chan (n_chan),
    .chw    (chw)
  ) u_track (
    .clk         (clk),
    .rst         (rst),
    .samp        (samp_q),
    .tail_gate   (bus.tail_gate),
    .err_clr     (bus.err_clr),
    .chan_valid  (bus.chan_valid),
    .chan_idx    (bus.chan_idx),
    .frame_start (bus.frame_start),
    .frame_end   (bus.frame_end),
    .in_flight   (bus.in_flight),
    .overrun     (bus.overrun),
    .short_frame (bus.short_frame)
  );

endmodule

// File: tb/tb_serialize_sched.sv
// Scoreboard bench for serialize_sched: an 8-cell chain model feeds the tail,
// a cycle-level reference predicts snaps and word labels.
module tb_serialize_sched;

  localparam int unsigned N   = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned CHW = 3;
`ifdef SERIALIZE_SCHED_CLAMP_EN
  localparam int OvExp = 0;
`else
  localparam int OvExp = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serialize_sched_if #(.cw(CW), .chw(CHW)) bus ();

  serialize_sched #(.n_chan(N), .cw(CW), .chw(CHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; int idx;} word_t;
  typedef struct {int c; int sig; longint exp; string name;} want_t;

  int     sq[$];
  word_t  wq[$];
  want_t  dq[$];
  int     n_chk  = 0;
  int     n_pass = 0;
  bit     kill_req = 1'b0;

  // Chain of N cells: a snap refills it, one word leaves per cycle.
  initial begin : chain
    int   rem;
    logic sp;
    rem = 0;
    bus.tail_gate = 1'b0;
    forever begin
      @(negedge clk);
      sp = bus.samp;
      @(posedge clk);
      #1;
      if (sp) rem = N;
      else if (rem > 0) rem--;
      if (kill_req) rem = 0;
      bus.tail_gate = (rem > 0);
    end
  end

  function automatic int effp(input int p);
    int e;
    e = (p < 2) ? 1 : p;
`ifdef SERIALIZE_SCHED_CLAMP_EN
    if (e < int'(N)) e = N;
`endif
    return e;
  endfunction

  function automatic longint sig_val(input int id);
    case (id)
      0: return longint'(bus.samp);
      1: return longint'(bus.chan_valid);
      2: return longint'(bus.chan_idx);
      3: return longint'(bus.frame_start);
      4: return longint'(bus.frame_end);
      5: return longint'(bus.in_flight);
      6: return longint'(bus.overrun);
      7: return longint'(bus.short_frame);
      8: return longint'(sq.size());
      9: return longint'(wq.size());
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d, want %0d", name, cyc, act, exp);
  endtask

  // Reference model plus monitor; expectations for cycle c+1 come from inputs
  // seen during cycle c.
  bit m_run  = 1'b0;
  int m_next = 0;
  int m_last = -1;
  int m_prev = -1;

  always @(negedge clk) begin : score
    bit    se, we;
    word_t w;
    want_t d;
    int    base;
    while (dq.size() > 0 && dq[0].c <= cyc) begin
      d = dq.pop_front();
      chk(d.name, sig_val(d.sig), d.exp);
    end
    se = (sq.size() > 0 && sq[0] == cyc);
    if (bus.samp || se) begin
      chk("samp", longint'(bus.samp), longint'(se));
      if (se) void'(sq.pop_front());
    end
    we = (wq.size() > 0 && wq[0].c == cyc);
    if (bus.chan_valid || we) begin
      chk("chan_valid", longint'(bus.chan_valid), longint'(we));
      if (we) begin
        w = wq.pop_front();
        chk("chan_idx", longint'(bus.chan_idx), w.idx);
        chk("frame_start", longint'(bus.frame_start), longint'(w.idx == 0));
        chk("frame_end", longint'(bus.frame_end), longint'(w.idx == N - 1));
      end
    end
    if (rst) begin
      m_run  = 1'b0;
      m_last = -1;
      m_prev = -1;
    end else begin
      base = (m_last >= 0 && m_last < cyc) ? m_last : m_prev;
      if (bus.tail_gate && base >= 0) wq.push_back('{cyc + 1, (cyc - base - 1) % N});
      if (!bus.enable) m_run = 1'b0;
      else if (!m_run || cyc + 1 == m_next) begin
        sq.push_back(cyc + 1);
        m_run  = 1'b1;
        m_next = cyc + 1 + effp(int'(bus.period));
        m_prev = m_last;
        m_last = cyc + 1;
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic want(input string name, input int sig, input longint exp);
    dq.push_back('{cyc, sig, exp, name});
  endtask

  task automatic want_zero(input string tag);
    for (int i = 0; i < 8; i++) want($sformatf("%s_sig%0d", tag, i), i, 0);
  endtask

  task automatic wait_samp();
    int k;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!bus.samp && k < 100);
    if (!bus.samp) want("samp_timeout", 0, 1);
  endtask

  initial begin : stim
    rst = 1'b1;
    bus.enable  = 1'b0;
    bus.period  = CW'(20);
    bus.err_clr = 1'b0;
    tick(2);
    want_zero("reset");
    rst = 1'b0;
    bus.enable = 1'b1;

    // Plain frames, period 20.
    wait_samp();
    tick(3);
    want("in_flight_mid", 5, 1);
    tick(12);
    want("in_flight_drained", 5, 0);
    wait_samp();
    wait_samp();
    tick(12);
    want("overrun_p20", 6, 0);
    want("short_p20", 7, 0);

    // Back-to-back, period == N.
    bus.period = CW'(N);
    tick(60);
    for (int i = 0; i < 8; i++) begin
      want("in_flight_b2b", 5, 1);
      tick(1);
    end
    want("overrun_b2b", 6, 0);

    // Too-short period, then recover and clear.
    bus.period = CW'(5);
    tick(20);
    want("overrun_p5", 6, OvExp);
    want("short_p5", 7, 0);
    bus.period = CW'(20);
    tick(12);
    bus.err_clr = 1'b1;
    want("overrun_pre_clr", 6, OvExp);
    tick(1);
    bus.err_clr = 1'b0;
    want("overrun_cleared", 6, 0);

    // Tail cut after three words.
    wait_samp();
    tick(3);
    want("short_before", 7, 0);
    #3 kill_req = 1'b1;
    tick(2);
    kill_req = 1'b0;
    want("short_set", 7, 1);
    wait_samp();
    tick(12);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    want("short_cleared", 7, 0);

    // Reset while word 4 is at the tail.
    wait_samp();
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    want_zero("midrst");
    tick(1);
    want("samp_after_rst", 0, 1);

    // Random periods >= N with occasional enable gaps.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 29) == 0) bus.period = CW'($urandom_range(N, N + 12));
      if ($urandom_range(0, 79) == 0) begin
        bus.enable = 1'b0;
        tick($urandom_range(N + 2, N + 12));
        bus.enable = 1'b1;
      end
      tick(1);
    end
    want("overrun_rand", 6, 0);
    want("short_rand", 7, 0);

    bus.enable = 1'b0;
    tick(30);
    want("samp_queue_empty", 8, 0);
    want("word_queue_empty", 9, 0);
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serialize_sched.md
Name: serialize_sched

Overview:
- Scheduler for a chain of n_chan serialize cells.
- Generates the periodic snap strobe (samp) that loads every cell in parallel.
- Tracks the words leaving the tail of the chain, using that cell's gate_out, and labels each word with its channel index and frame boundaries.
- Flags scheduling overruns and malformed frames. Sits between the decimation/CIC control and the downstream consumer of the serial stream.

Parameters:
- n_chan, 8, number of serialize cells in the chain (words per frame), 2..256.
- cw, 16, width of the period counter and of the period input.
- chw, 3, width of chan_idx; must satisfy 2**chw >= n_chan.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  run/stop for snap generation.
- period  input  cw  cycles between successive samp pulses; sampled at each samp.
- samp  output  1  one-cycle snap strobe, drives samp of all cells.
- tail_gate  input  1  gate_out of the last cell in the chain.
- chan_valid  output  1  registered copy of tail_gate; qualifies the tail word.
- chan_idx  output  chw  channel index of the word qualified by chan_valid.
- frame_start  output  1  high with chan_valid when chan_idx==0.
- frame_end  output  1  high with chan_valid when chan_idx==n_chan-1.
- in_flight  output  1  a frame is launched and not yet fully drained.
- overrun  output  1  sticky: samp issued while in_flight.
- short_frame  output  1  sticky: tail_gate fell before n_chan words.
- err_clr  input  1  clears both sticky flags.

Behaviour:
- Reset: all outputs 0; period counter 0; word counter 0; effective period register 0.
- Snap generation:
  - States are IDLE (enable low) and RUN.
  - IDLE: counter held at 0 and no samp. Leaving IDLE asserts samp on the first clk edge where enable is seen high.
  - RUN: samp is asserted when the counter equals 0; the counter then reloads with eff_period-1 and decrements every cycle. This gives a samp every eff_period cycles.
  - eff_period is captured from period only on samp cycles; a mid-interval change takes effect after the next samp.
  - period==0 or period==1 are treated as 1 (samp every cycle) before the clamping rule below.
  - enable dropping mid-interval returns to IDLE immediately with no further samp. A frame already in flight still drains and is tracked normally.
- Frame tracking:
  - Cell latency is 1 cycle: samp at cycle t gives tail_gate high for cycles t+1..t+n_chan.
  - chan_valid, chan_idx, frame_start and frame_end are registered, one cycle after tail_gate.
  - The word counter increments on each tail_gate-high cycle. It wraps to 0 after n_chan-1, so a back-to-back frame (period==n_chan) runs continuously.
  - in_flight is set on samp and cleared on the cycle frame_end is issued, unless a samp occurs in that same cycle, in which case it stays set.
- Errors:
  - tail_gate low while the word counter is nonzero sets short_frame and resets the counter to 0.
  - samp issued while in_flight (and not in the frame_end cycle) sets overrun. The new frame overwrites the chain, and the word counter restarts at 0 on the next tail_gate.
  - err_clr clears both flags the next cycle. An error event in the same cycle as err_clr wins, so the flag is set.
- Reset mid-operation: everything returns to reset values the next cycle. Words already in the chain are ignored until the next frame_start alignment; the counter restarts from 0.

Optional Feature:
- SERIALIZE_SCHED_CLAMP_EN defined: eff_period = max(period, n_chan). overrun can then only come from a stuck or extended tail_gate.
- Undefined: period is used as-is (after the 0/1 rule), and overrun reports too-short periods.

Decomposition:
- Package serialize_sched_pkg holds:
  - state encoding localparams (ST_IDLE, ST_RUN);
  - a function computing the minimum chw from n_chan, used for a parameter sanity check.
- Sub-module serialize_frame_track holds the word counter, chan_* outputs, in_flight and both error flags. Inputs: samp, tail_gate, err_clr.
- The top level keeps the period counter and state machine.

Test Plan:
- n_chan=8, period=20, enable rises at cycle 10, tail fed by an 8-cell chain model:
  - samp at 10, 30, 50;
  - chan_valid cycles 12..19 with chan_idx 0..7;
  - frame_start at 12, frame_end at 19; no flags.
- period=8 (== n_chan):
  - continuous chan_valid, chan_idx wrapping 7→0;
  - in_flight stays 1; overrun stays 0.
- period=5, clamp undefined: second samp at +5 sets overrun; err_clr pulse clears it one cycle later.
- period=5, clamp defined: samp spacing is 8; overrun never sets.
- Force tail_gate low after 3 words: short_frame=1 and chan_idx restarts at 0 on the next frame.
- rst pulse mid-frame at word 4: all outputs 0 next cycle. enable still high: samp on the first cycle after rst falls, and the tracked frame indices start at 0.
